multdiv_seq: RTL and testbench

- Multi-cycle signed 32-bit multiply/divide sequencer for the CPU execute stage.
- Time-shares a single instance of the team's 32-bit carry-lookahead adder (cla_32: A, B, opcode, S, cout; opcode[0]=1 selects A−B).
- Runs radix-2 Booth multiplication and restoring division on magnitudes with a sign fix-up.
- The pipeline stalls while busy is high and captures the result on data_resultRDY.

---
 rtl/multdiv_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_multdiv_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed 32-bit multiply/divide sequencer for the
// execute stage. One shared cla_32 adder serves the Booth accumulate step,
// the operand/result negations and the restoring-division subtract.
// cla4 / cla_32 are the team's carry-lookahead adder, carried in this file so
// the block is self-contained.

// 4-bit carry-lookahead group with group generate/propagate outputs.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g_grp,
    output logic       p_grp
);
    logic [3:0] g, p;
    logic [3:0] c;

    // Bit carries by full lookahead within the group.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        s     = p ^ c;
        g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_grp = &p;
    end
endmodule

// 32-bit adder/subtractor: opcode[0]=1 computes A-B as A + ~B + 1.
module cla_32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [0:0]  opcode,
    output logic [31:0] S,
    output logic        cout
);
    logic [31:0] bx;
    logic [8:0]  c;
    logic [7:0]  gg, pg;

    assign bx = B ^ {32{opcode[0]}};

    for (genvar i = 0; i < 8; i++) begin : g_grp
        cla4 u_cla4 (
            .a    (A[4*i +: 4]),
            .b    (bx[4*i +: 4]),
            .cin  (c[i]),
            .s    (S[4*i +: 4]),
            .g_grp(gg[i]),
            .p_grp(pg[i])
        );
    end

    // Group carries chained from the per-group generate/propagate terms.
    always_comb begin
        c[0] = opcode[0];
        for (int i = 0; i < 8; i++) c[i+1] = gg[i] | (pg[i] & c[i]);
    end

    assign cout = c[8];
endmodule

module multdiv_seq #(
    parameter int WIDTH         = 32,   // only 32: the shared adder is fixed-width
    parameter int MULT_PRIORITY = 1     // 1: multiply wins a simultaneous start
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE, MULT, DPRE_A, DPRE_B, DIV, DPOST, DONE
    } state_t;

    // Operand selection for the shared adder.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
    } add_req_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] m_reg;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] p_hi, p_lo;   // Booth product halves
    logic             p_q;          // Booth extra bit
    logic [WIDTH-1:0] rem, quo;     // division remainder / quotient
    logic [CW-1:0]    cnt;
    logic             s_a, s_b, dz;

    logic             start_mult, start_div;
    add_req_t         add_req;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic [1:0]       booth;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] b_eff;
    logic             add_ovf;
    logic [WIDTH:0]   acc_ext;      // 33-bit Booth accumulator before the shift
    logic [WIDTH:0]   prod_top;
    logic             mult_ovf;

    assign start_mult = ctrl_MULT && ((MULT_PRIORITY != 0) || !ctrl_DIV);
    assign start_div  = ctrl_DIV  && ((MULT_PRIORITY == 0) || !ctrl_MULT);

    assign booth  = {p_lo[0], p_q};
    assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};

    // Route the right operands into the shared adder for the current state.
    always_comb begin
        add_req = '0;
        case (state)
            MULT:   begin add_req.a = p_hi; add_req.b = m_reg; add_req.sub = (booth == 2'b10); end
            DPRE_A: begin add_req.b = quo;   add_req.sub = 1'b1; end
            DPRE_B: begin add_req.b = m_reg; add_req.sub = 1'b1; end
            DIV:    begin add_req.a = rem_sh; add_req.b = m_reg; add_req.sub = 1'b1; end
            DPOST:  begin add_req.b = quo;   add_req.sub = 1'b1; end
            default: ;
        endcase
    end

    cla_32 u_add (
        .A     (add_req.a),
        .B     (add_req.b),
        .opcode(add_req.sub),
        .S     (add_s),
        .cout  (add_cout)
    );

    // Booth accumulate: the shift-in bit is the true sign of the 33-bit sum,
    // so M = 0x80000000 (whose negation does not fit 32 bits) stays exact.
    always_comb begin
        b_eff   = add_req.sub ? ~add_req.b : add_req.b;
        add_ovf = (add_req.a[WIDTH-1] == b_eff[WIDTH-1]) && (add_s[WIDTH-1] != add_req.a[WIDTH-1]);
        if (booth == 2'b01 || booth == 2'b10) acc_ext = {add_s[WIDTH-1] ^ add_ovf, add_s};
        else                                  acc_ext = {p_hi[WIDTH-1], p_hi};
        prod_top = {p_hi, p_lo[WIDTH-1]};
        mult_ovf = !((&prod_top) || !(|prod_top));
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; starts are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mult)     state_nxt = MULT;
                else if (start_div) state_nxt = (data_operandB == '0) ? DPOST : DPRE_A;
            end
            MULT:    if (cnt == LAST) state_nxt = DONE;
            DPRE_A:  state_nxt = DPRE_B;
            DPRE_B:  state_nxt = DIV;
            DIV:     if (cnt == LAST) state_nxt = DPOST;
            DPOST:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; result and exception change only on entry to DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reg          <= '0;
            p_hi           <= '0;
            p_lo           <= '0;
            p_q            <= 1'b0;
            rem            <= '0;
            quo            <= '0;
            cnt            <= '0;
            s_a            <= 1'b0;
            s_b            <= 1'b0;
            dz             <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        m_reg <= data_operandB;
                        p_hi  <= '0;
                        p_lo  <= data_operandA;
                        p_q   <= 1'b0;
                        cnt   <= '0;
                    end else if (start_div) begin
                        m_reg <= data_operandB;
                        quo   <= data_operandA;
                        rem   <= '0;
                        cnt   <= '0;
                        dz    <= (data_operandB == '0);
                        if (data_operandB != '0) begin
                            s_a <= data_operandA[WIDTH-1];
                            s_b <= data_operandB[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    if (cnt != LAST) begin
                        p_hi <= acc_ext[WIDTH:1];
                        p_lo <= {acc_ext[0], p_lo[WIDTH-1:1]};
                        p_q  <= p_lo[0];
                        cnt  <= cnt + 1'b1;
                    end else begin
                        data_result    <= p_lo;
                        data_exception <= mult_ovf;
                    end
                end
                DPRE_A: if (s_a) quo   <= add_s;
                DPRE_B: if (s_b) m_reg <= add_s;
                DIV: begin
                    // cout=1 means no borrow: shifted remainder >= divisor.
                    if (cnt != LAST) begin
                        rem <= add_cout ? add_s : rem_sh;
                        quo <= {quo[WIDTH-2:0], add_cout};
                        cnt <= cnt + 1'b1;
                    end
                end
                DPOST: begin
                    if (dz) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= (s_a ^ s_b) ? add_s : quo;
                        data_exception <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: table of vectors with a scoreboard of
// expected results, random vectors against a behavioural model, and
// hand-written reset / handshake sequences.
module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_seq #(.WIDTH(32), .MULT_PRIORITY(1)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        is_div;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b, input logic is_div);
        exp_t   e;
        longint p;
        if (!is_div) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
            e.lat = 33;
        end else if (b == 32'h0) begin
            e.res = '0; e.exc = 1'b1; e.lat = 1;
        end else begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = a;
            else e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
            e.lat = 36;
        end
        return e;
    endfunction

    // Drive one start pulse; operands are scrambled after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic m, input logic d, input exp_t e);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        sb_q.push_back(e);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait for RDY (bounded), pop the scoreboard and compare. div_at>0 pulses
    // a divide-by-zero start that many cycles into the operation.
    task automatic wait_result(input string tag, input int div_at);
        int   lat = 0;
        bit   got = 0;
        exp_t e;
        while (!got && lat < 100) begin
            @(posedge clock);
            lat++;
            #1;
            ctrl_DIV = (div_at != 0 && lat == div_at);
            if (ctrl_DIV) data_operandB = '0;
            if (data_resultRDY) got = 1;
        end
        ctrl_DIV = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: no RDY within %0d cycles", tag, lat);
            return;
        end
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_scoreboard: RDY with no expected result queued", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_result"}, data_result, e.res);
        chk({tag, "_exc"},    32'(data_exception), 32'(e.exc));
        chk({tag, "_lat"},    32'(lat), 32'(e.lat));
        chk({tag, "_busy"},   32'(busy), 32'd1);
        @(posedge clock);
        #1;
        chk({tag, "_rdy_1cyc"}, 32'(data_resultRDY), 32'd0);
        chk({tag, "_hold"},     data_result, e.res);
        chk({tag, "_idle"},     32'(busy), 32'd0);
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic d,
                                input logic [31:0] r, input logic x, input int l);
        vec_t v;
        v.a = a; v.b = b; v.is_div = d; v.res = r; v.exc = x; v.lat = l;
        return v;
    endfunction

    initial begin
        exp_t e;
        int   cnt;
        logic [31:0] ra, rb;

        vecs.push_back(mk(32'd7,         32'd6,          0, 32'd42,         0, 33));
        vecs.push_back(mk(-32'sd3,       32'h8000_0000,  0, 32'h8000_0000,  1, 33));
        vecs.push_back(mk(32'h8000_0000, 32'd1,          0, 32'h8000_0000,  0, 33));
        vecs.push_back(mk(-32'sd5,       -32'sd7,        0, 32'd35,         0, 33));
        vecs.push_back(mk(32'h0001_0000, 32'h0001_0000,  0, 32'd0,          1, 33));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'd2,          0, 32'hFFFF_FFFE,  1, 33));
        vecs.push_back(mk(32'd100,       32'd7,          1, 32'd14,         0, 36));
        vecs.push_back(mk(-32'sd100,     32'd7,          1, -32'sd14,       0, 36));
        vecs.push_back(mk(32'd100,       -32'sd7,        1, -32'sd14,       0, 36));
        vecs.push_back(mk(-32'sd100,     -32'sd7,        1, 32'd14,         0, 36));
        vecs.push_back(mk(32'd5,         32'd0,          1, 32'd0,          1, 1));
        vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF,  1, 32'h8000_0000,  0, 36));
        vecs.push_back(mk(32'd3,         32'd5,          1, 32'd0,          0, 36));

        // Asynchronous reset from the start.
        #1 reset_n = 1'b0;
        #1;
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc",    32'(data_exception), 32'd0);
        chk("reset_rdy",    32'(data_resultRDY), 32'd0);
        chk("reset_busy",   32'(busy), 32'd0);
        #20;
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            e.res = vecs[i].res; e.exc = vecs[i].exc; e.lat = vecs[i].lat;
            start_op(vecs[i].a, vecs[i].b, !vecs[i].is_div, vecs[i].is_div, e);
            wait_result($sformatf("vec%0d", i), 0);
        end

        // Random vectors checked against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 2000)) : $urandom;
            if (i == 5) rb = -rb;
            e = ref_op(ra, rb, i[0]);
            start_op(ra, rb, !i[0], i[0], e);
            wait_result($sformatf("rnd%0d", i), 0);
        end

        // Both starts together: multiply wins.
        e.res = 32'd700; e.exc = 1'b0; e.lat = 33;
        start_op(32'd100, 32'd7, 1'b1, 1'b1, e);
        wait_result("both_starts", 0);

        // Divide start while busy is ignored.
        e.res = 32'd81; e.exc = 1'b0; e.lat = 33;
        start_op(32'd9, 32'd9, 1'b1, 1'b0, e);
        wait_result("div_while_busy", 5);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (busy || data_resultRDY) cnt++;
        end
        chk("div_while_busy_no_extra", 32'(cnt), 32'd0);

        // Reset mid-multiply: previous result (81) is cleared immediately.
        @(negedge clock);
        data_operandA = 32'd7; data_operandB = 32'd6; ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_result", data_result, 32'd0);
        chk("midrst_exc",    32'(data_exception), 32'd0);
        chk("midrst_busy",   32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) cnt++;
        end
        chk("midrst_no_rdy", 32'(cnt), 32'd0);
        e.res = 32'd42; e.exc = 1'b0; e.lat = 33;
        start_op(32'd7, 32'd6, 1'b1, 1'b0, e);
        wait_result("restart", 0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
